// File: rtl/mole_spawner.sv
// Game-side mole generator: pseudo-random position, fixed visible window, hit/miss accounting.
// Latency: every output is registered; mole_visible rises GAP_CYCLES edges after entering GAP.
// No backpressure: mole_is_hitted is a level sampled every cycle; pulses last exactly one cycle.
module mole_spawner #(
  parameter int          UP_CYCLES  = 50_000_000,
  parameter int          GAP_CYCLES = 12_500_000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               is_started,
  input  logic               mole_is_hitted,
  output logic [1:0]         mole_row,
  output logic [1:0]         mole_col,
  output logic               mole_visible,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] misses,
  output logic               hit_pulse,
  output logic               miss_pulse
);

  localparam int MAX_CYCLES = (UP_CYCLES > GAP_CYCLES) ? UP_CYCLES : GAP_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES);
  localparam logic [TW-1:0] UP_LAST  = TW'(UP_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [SCORE_W-1:0] CNT_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {IDLE, GAP, UP} state_t;

  state_t             state_q, state_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               armed_q, armed_d;
  logic [3:0]         pos_d;
  logic               vis_d, hit_d, miss_d;
  logic [SCORE_W-1:0] score_d, misses_d;
  logic               fb;
  logic [3:0]         cand, pick;

  // Taps 16,14,13,11 of the Fibonacci polynomial; feedback enters bit 0.
  assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  // The displayed position doubles as the "previous position": it only changes when a new mole spawns.
  assign cand = lfsr_q[3:0];
  assign pick = (cand == {mole_row, mole_col}) ? cand + 4'd1 : cand;

  // Next-state and next-output logic for the spawn/visible/score sequencing.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    lfsr_d   = {lfsr_q[14:0], fb};
    armed_d  = armed_q;
    pos_d    = {mole_row, mole_col};
    vis_d    = mole_visible;
    score_d  = score;
    misses_d = misses;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    case (state_q)
      IDLE: begin
        vis_d   = 1'b0;
        timer_d = '0;
        if (is_started) begin
          state_d  = GAP;
          score_d  = '0;
          misses_d = '0;
        end
      end
      GAP: begin
        if (!is_started) begin
          state_d = IDLE;
          timer_d = '0;
          vis_d   = 1'b0;
        end else if (timer_q == GAP_LAST) begin
          state_d = UP;
          timer_d = '0;
          vis_d   = 1'b1;
          armed_d = 1'b0;
          pos_d   = pick;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      UP: begin
        if (!is_started) begin
          state_d = IDLE;
          timer_d = '0;
          vis_d   = 1'b0;
        end else begin
          // A key must be seen released during this mole before a press counts.
          if (!mole_is_hitted) armed_d = 1'b1;
          if (mole_is_hitted && armed_q) begin
            score_d = (score == CNT_MAX) ? score : score + SCORE_W'(1);
            hit_d   = 1'b1;
            vis_d   = 1'b0;
            state_d = GAP;
            timer_d = '0;
          end else if (timer_q == UP_LAST) begin
            misses_d = (misses == CNT_MAX) ? misses : misses + SCORE_W'(1);
            miss_d   = 1'b1;
            vis_d    = 1'b0;
            state_d  = GAP;
            timer_d  = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        vis_d   = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      lfsr_q       <= LFSR_SEED;
      armed_q      <= 1'b0;
      mole_row     <= 2'd0;
      mole_col     <= 2'd0;
      mole_visible <= 1'b0;
      score        <= '0;
      misses       <= '0;
      hit_pulse    <= 1'b0;
      miss_pulse   <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      lfsr_q       <= lfsr_d;
      armed_q      <= armed_d;
      mole_row     <= pos_d[3:2];
      mole_col     <= pos_d[1:0];
      mole_visible <= vis_d;
      score        <= score_d;
      misses       <= misses_d;
      hit_pulse    <= hit_d;
      miss_pulse   <= miss_d;
    end
  end

endmodule
